// File: rtl/boss_ctrl_if.sv
// -----------------------------------------------------------------------------
// boss_ctrl_if
//
// Bundles the signals between the game state machine / renderer side and the
// stage-3 boss sequencer. clk and rst stay plain ports on the modules.
//
//   state      game state (4 bits); STAGE3 (6) enables the boss
//   tick       one-cycle pulse per video frame
//   hit        one-cycle pulse, a player shot overlapped the boss
//   boss_x     sprite left edge (9 bits)
//   boss_y     sprite top edge (9 bits)
//   boss_state sprite frame index: 0-3 walk, 4 hit flash, 5 dead
//   boss_hp    remaining hit points
//   boss_dead  high while the boss is dead
//
// Modports:
//   master  drives state/tick/hit, observes the boss outputs
//   slave   the boss sequencer itself
// -----------------------------------------------------------------------------
interface boss_ctrl_if;
    logic [3:0] state;
    logic       tick;
    logic       hit;
    logic [8:0] boss_x;
    logic [8:0] boss_y;
    logic [3:0] boss_state;
    logic [3:0] boss_hp;
    logic       boss_dead;

    modport master (
        output state, tick, hit,
        input  boss_x, boss_y, boss_state, boss_hp, boss_dead
    );

    modport slave (
        input  state, tick, hit,
        output boss_x, boss_y, boss_state, boss_hp, boss_dead
    );
endinterface

// File: rtl/boss_ctrl.sv
// -----------------------------------------------------------------------------
// boss_ctrl
//
// Sequencer for the stage-3 boss sprite. While the game is in STAGE3 the boss
// descends from y=0 to Y_PATROL, then patrols left/right between X_MIN and
// X_MAX one pixel per frame tick, with a 4-frame walk animation. Player hits
// cost one hit point and trigger a HIT_TICKS-long flash; the last hit point
// kills the boss. Leaving STAGE3 returns everything to reset values so a
// re-entered stage restarts at full HP.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   boss_ctrl_if.slave (state/tick/hit in, boss_* out)
//
// All outputs are registered; a tick or hit sampled at an edge shows on the
// outputs right after that edge.
// -----------------------------------------------------------------------------
module boss_ctrl #(
    parameter int X_MIN     = 20,
    parameter int X_MAX     = 300,
    parameter int X_START   = 155,
    parameter int Y_PATROL  = 40,
    parameter int HP_INIT   = 8,
    parameter int ANIM_DIV  = 8,
    parameter int HIT_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    boss_ctrl_if.slave bus
);

    localparam logic [3:0] STAGE3      = 4'd6;
    localparam logic [3:0] FRAME_FLASH = 4'd4;
    localparam logic [3:0] FRAME_DEAD  = 4'd5;

    localparam logic [8:0] X_MIN_W    = 9'(X_MIN);
    localparam logic [8:0] X_MAX_W    = 9'(X_MAX);
    localparam logic [8:0] X_START_W  = 9'(X_START);
    localparam logic [8:0] Y_PATROL_W = 9'(Y_PATROL);
    localparam logic [3:0] HP_INIT_W  = 4'(HP_INIT);
    localparam logic [7:0] ANIM_LAST  = 8'(ANIM_DIV - 1);
    localparam logic [7:0] FLASH_LAST = 8'(HIT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTER,
        S_PATROL,
        S_HIT,
        S_DEAD
    } fsm_t;

    fsm_t       fsm;
    logic [8:0] x_q;
    logic [8:0] y_q;
    logic [3:0] frame_q;
    logic [3:0] hp_q;
    logic       dead_q;
    logic       dir;      // 1 = moving right
    logic [7:0] acnt;     // walk animation prescaler
    logic [7:0] fcnt;     // hit-flash tick counter

    logic       active;
    logic       anim_wrap;
    logic [7:0] acnt_next;
    logic [3:0] frame_walk_next;
    logic [8:0] x_step;
    logic       dir_step;

    assign active = (bus.state == STAGE3);

    // Walk animation: the frame index advances once every ANIM_DIV ticks and
    // only ever cycles through 0..3.
    assign anim_wrap       = (acnt == ANIM_LAST);
    assign acnt_next       = anim_wrap ? 8'd0 : acnt + 8'd1;
    assign frame_walk_next = anim_wrap ? {2'b00, frame_q[1:0] + 2'd1} : frame_q;

    // Patrol step. Reaching a bound turns the boss around on the same tick and
    // steps it one pixel back inside, so the position never overshoots.
    always_comb begin
        x_step   = x_q;
        dir_step = dir;
        if (dir && x_q == X_MAX_W) begin
            x_step   = X_MAX_W - 9'd1;
            dir_step = 1'b0;
        end else if (!dir && x_q == X_MIN_W) begin
            x_step   = X_MIN_W + 9'd1;
            dir_step = 1'b1;
        end else if (dir) begin
            x_step = x_q + 9'd1;
        end else begin
            x_step = x_q - 9'd1;
        end
    end

    // NOTE: every state register uses non-blocking assignment so all of them
    // update together from the values seen at the same edge; blocking here
    // would let later statements see half-updated state.
    always_ff @(posedge clk) begin
        // NOTE: reset and stage exit share one path; every register, including
        // counters and direction, is restored so a re-entered stage is a clean
        // restart rather than a continuation.
        if (rst || !active) begin
            fsm     <= S_IDLE;
            x_q     <= X_START_W;
            y_q     <= 9'd0;
            frame_q <= 4'd0;
            hp_q    <= HP_INIT_W;
            dead_q  <= 1'b0;
            dir     <= 1'b1;
            acnt    <= 8'd0;
            fcnt    <= 8'd0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    fsm <= S_ENTER;
                end

                // Descent: x stays at X_START, hits are ignored.
                S_ENTER: begin
                    if (bus.tick) begin
                        y_q     <= y_q + 9'd1;
                        acnt    <= acnt_next;
                        frame_q <= frame_walk_next;
                        if (y_q + 9'd1 == Y_PATROL_W) begin
                            fsm <= S_PATROL;
                        end
                    end
                end

                // A hit takes priority over a tick in the same cycle: the
                // boss neither moves nor animates on that cycle.
                S_PATROL: begin
                    if (bus.hit) begin
                        if (hp_q > 4'd1) begin
                            hp_q    <= hp_q - 4'd1;
                            frame_q <= FRAME_FLASH;
                            fcnt    <= 8'd0;
                            fsm     <= S_HIT;
                        end else begin
                            hp_q    <= 4'd0;
                            frame_q <= FRAME_DEAD;
                            dead_q  <= 1'b1;
                            fsm     <= S_DEAD;
                        end
                    end else if (bus.tick) begin
                        x_q     <= x_step;
                        dir     <= dir_step;
                        acnt    <= acnt_next;
                        frame_q <= frame_walk_next;
                    end
                end

                // Flash: position and direction frozen, hits ignored. The
                // walk animation restarts from frame 0 when patrol resumes.
                S_HIT: begin
                    if (bus.tick) begin
                        if (fcnt == FLASH_LAST) begin
                            fcnt    <= 8'd0;
                            acnt    <= 8'd0;
                            frame_q <= 4'd0;
                            fsm     <= S_PATROL;
                        end else begin
                            fcnt <= fcnt + 8'd1;
                        end
                    end
                end

                // Dead: everything held until the stage is left.
                S_DEAD: begin
                    frame_q <= FRAME_DEAD;
                    dead_q  <= 1'b1;
                end

                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.boss_x     = x_q;
    assign bus.boss_y     = y_q;
    assign bus.boss_state = frame_q;
    assign bus.boss_hp    = hp_q;
    assign bus.boss_dead  = dead_q;

endmodule

// File: tb/tb_boss_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boss_ctrl
//
// Directed bench for boss_ctrl with hand-computed expectations: entry descent,
// patrol bounce at both bounds, hit flash, kill, stage exit mid-flash and
// synchronous reset during patrol.
// -----------------------------------------------------------------------------
module tb_boss_ctrl;

    logic clk = 1'b0;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    boss_ctrl_if bus ();

    boss_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Apply tick/hit for exactly one clock edge; outputs are sampled 1 ns
    // after that edge.
    task automatic cyc(input logic t, input logic h);
        bus.tick = t;
        bus.hit  = h;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
        bus.hit  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"},     32'(bus.boss_x),     32'd155);
        check({tag, "_y"},     32'(bus.boss_y),     32'd0);
        check({tag, "_frame"}, 32'(bus.boss_state), 32'd0);
        check({tag, "_hp"},    32'(bus.boss_hp),    32'd8);
        check({tag, "_dead"},  32'(bus.boss_dead),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hp_exp;

        rst       = 1'b1;
        bus.state = 4'd0;
        bus.tick  = 1'b0;
        bus.hit   = 1'b0;
        cyc(0, 0);
        cyc(0, 0);
        rst = 1'b0;
        check_reset_vals("reset");

        // Tick outside STAGE3 does nothing.
        cyc(1, 0);
        check("idle_tick_y", 32'(bus.boss_y), 32'd0);

        // Entry: one cycle to ENTER, then 40 ticks of descent.
        bus.state = 4'd6;
        cyc(0, 0);
        check("enter_y0", 32'(bus.boss_y), 32'd0);
        for (int i = 1; i <= 40; i++) begin
            cyc(1, 0);
            check($sformatf("enter_y_%0d", i), 32'(bus.boss_y), 32'(i));
            check($sformatf("enter_x_%0d", i), 32'(bus.boss_x), 32'd155);
            if (i % 8 == 0)
                check($sformatf("enter_frame_%0d", i), 32'(bus.boss_state), 32'((i / 8) % 4));
        end

        // Patrol right: 145 ticks from 155 reach 300.
        for (int i = 1; i <= 145; i++) begin
            cyc(1, 0);
            if (i % 29 == 0)
                check($sformatf("patrol_x_%0d", i), 32'(bus.boss_x), 32'(155 + i));
        end
        check("right_bound", 32'(bus.boss_x), 32'd300);
        cyc(1, 0);
        check("right_bounce", 32'(bus.boss_x), 32'd299);
        cyc(1, 0);
        check("moving_left", 32'(bus.boss_x), 32'd298);
        check("patrol_y", 32'(bus.boss_y), 32'd40);

        // Patrol left to X_MIN and bounce.
        for (int i = 0; i < 278; i++) cyc(1, 0);
        check("left_bound", 32'(bus.boss_x), 32'd20);
        cyc(1, 0);
        check("left_bounce", 32'(bus.boss_x), 32'd21);
        cyc(1, 0);
        check("moving_right", 32'(bus.boss_x), 32'd22);

        // Hit together with tick: hit wins, no movement.
        cyc(1, 1);
        check("hit_hp",    32'(bus.boss_hp),    32'd7);
        check("hit_frame", 32'(bus.boss_state), 32'd4);
        check("hit_x",     32'(bus.boss_x),     32'd22);
        cyc(0, 1);
        check("hit_ignored_hp", 32'(bus.boss_hp), 32'd7);
        for (int i = 1; i <= 7; i++) begin
            cyc(1, (i == 3));
            check($sformatf("flash_frame_%0d", i), 32'(bus.boss_state), 32'd4);
            check($sformatf("flash_hp_%0d", i),    32'(bus.boss_hp),    32'd7);
        end
        check("flash_x", 32'(bus.boss_x), 32'd22);
        cyc(1, 0);
        check("flash_end_frame", 32'(bus.boss_state), 32'd0);
        check("flash_end_x",     32'(bus.boss_x),     32'd22);
        cyc(1, 0);
        check("patrol_resume_x", 32'(bus.boss_x), 32'd23);

        // Kill: hits without tick, each followed by a full flash.
        hp_exp = 7;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 1);
            hp_exp--;
            check($sformatf("kill_hp_%0d", k), 32'(bus.boss_hp), 32'(hp_exp));
            check($sformatf("kill_frame_%0d", k), 32'(bus.boss_state), 32'd4);
            for (int t = 0; t < 8; t++) cyc(1, 0);
            check($sformatf("kill_resume_%0d", k), 32'(bus.boss_state), 32'd0);
        end
        cyc(0, 1);
        check("dead_hp",    32'(bus.boss_hp),    32'd0);
        check("dead_frame", 32'(bus.boss_state), 32'd5);
        check("dead_flag",  32'(bus.boss_dead),  32'd1);
        for (int i = 0; i < 20; i++) cyc(1, i[0]);
        check("dead_hold_x",     32'(bus.boss_x),     32'd23);
        check("dead_hold_y",     32'(bus.boss_y),     32'd40);
        check("dead_hold_frame", 32'(bus.boss_state), 32'd5);
        check("dead_hold_hp",    32'(bus.boss_hp),    32'd0);
        check("dead_hold_flag",  32'(bus.boss_dead),  32'd1);

        // Leave the stage, re-enter, go to HIT, then leave mid-flash together
        // with a hit.
        bus.state = 4'd8;
        cyc(0, 0);
        check_reset_vals("exit_dead");
        bus.state = 4'd6;
        cyc(0, 0);
        for (int i = 0; i < 40; i++) cyc(1, 0);
        check("reenter_y", 32'(bus.boss_y), 32'd40);
        cyc(0, 1);
        check("reenter_hit_hp", 32'(bus.boss_hp), 32'd7);
        cyc(1, 0);
        cyc(1, 0);
        bus.state = 4'd8;
        cyc(0, 1);
        check_reset_vals("exit_flash");

        // Re-entry restarts at full HP; hits during descent are ignored.
        bus.state = 4'd6;
        cyc(0, 0);
        cyc(1, 1);
        check("restart_y",  32'(bus.boss_y),  32'd1);
        check("restart_hp", 32'(bus.boss_hp), 32'd8);
        for (int i = 0; i < 39; i++) cyc(1, 0);
        for (int i = 0; i < 45; i++) cyc(1, 0);
        check("pre_rst_x", 32'(bus.boss_x), 32'd200);

        // Synchronous reset during patrol.
        rst = 1'b1;
        cyc(1, 0);
        rst = 1'b0;
        check_reset_vals("sync_rst");
        cyc(1, 0);
        check("post_rst_idle_y", 32'(bus.boss_y), 32'd0);
        cyc(1, 0);
        check("post_rst_enter_y", 32'(bus.boss_y), 32'd1);
        check("post_rst_enter_x", 32'(bus.boss_x), 32'd155);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
